cv32e40x_rvfi_data_obi_tracker: RTL

Downstream consumer of the RVFI data OBI alignment stage: collects the aligned data transactions of each LSU instruction and presents them as RVFI memory fields when that instruction retires in WB. A split (misaligned) access produces two transactions, which are merged into one record. A small FIFO decouples transaction issue in EX from retirement in WB. The block is bhv-only and sits inside the RVFI wrapper.

---
 rtl/cv32e40x_pkg.sv | 15 +
 rtl/cv32e40x_rvfi_pkg.sv | 22 ++
 rtl/cv32e40x_rvfi_sync_fifo.sv | 61 ++++++
 rtl/cv32e40x_rvfi_data_obi_tracker.sv | 126 ++++++++++++
 4 files changed

// File: rtl/cv32e40x_pkg.sv
// Core-wide types used by the RVFI tracker: the aligned OBI data request.
package cv32e40x_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic [5:0]  atop;
    logic [3:0]  be;
    logic [1:0]  memtype;
    logic [2:0]  prot;
    logic        dbg;
    logic [31:0] wdata;
    logic        we;
  } obi_data_req_t;

endpackage

// File: rtl/cv32e40x_rvfi_pkg.sv
// RVFI memory record shared by the data OBI tracker and its record FIFO.
package cv32e40x_rvfi_pkg;

  localparam int unsigned MAX_TRANS = 2;

  typedef struct packed {
    logic [MAX_TRANS-1:0][31:0] addr;
    logic [MAX_TRANS-1:0][3:0]  be;
    logic [MAX_TRANS-1:0][31:0] wdata;
    logic                       we;
  } rvfi_mem_rec_t;

  // Byte mask of a record, only when its direction matches the requested one
  function automatic logic [7:0] rec_mask(input rvfi_mem_rec_t rec, input logic is_write);
    if (rec.we == is_write) begin
      return rec.be;
    end else begin
      return 8'h00;
    end
  endfunction

endpackage

// File: rtl/cv32e40x_rvfi_sync_fifo.sv
// Generic synchronous FIFO with flush and occupancy; read data is the head, combinational.
module cv32e40x_rvfi_sync_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic [AW:0]      o_cnt
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_cnt;
  logic             w_wr;
  logic             w_rd;

  assign o_full  = (r_cnt == (AW+1)'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_cnt   = r_cnt;
  assign o_rdata = r_mem[r_rptr];

  // A write into a full FIFO is only legal when the head leaves in the same cycle
  assign w_wr = i_push && (!o_full || i_pop) && !i_flush;
  assign w_rd = i_pop && !o_empty && !i_flush;

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wptr] <= i_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_wr) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_rd) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({w_wr, w_rd})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/cv32e40x_rvfi_data_obi_tracker.sv
// Collects the aligned OBI data transactions of each LSU instruction and presents
// them as RVFI memory fields when that instruction retires in WB.
module cv32e40x_rvfi_data_obi_tracker
  import cv32e40x_pkg::*;
  import cv32e40x_rvfi_pkg::rvfi_mem_rec_t;
  import cv32e40x_rvfi_pkg::rec_mask;
#(
  parameter int unsigned DEPTH     = 2,
  parameter int unsigned MAX_TRANS = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  obi_data_req_t lsu_data_trans_i,
  input  logic          lsu_data_trans_valid_i,
  input  logic          lsu_trans_last_i,
  input  logic          wb_lsu_retire_i,
  input  logic          flush_i,
  output logic [63:0]   rvfi_mem_addr_o,
  output logic [7:0]    rvfi_mem_rmask_o,
  output logic [7:0]    rvfi_mem_wmask_o,
  output logic [63:0]   rvfi_mem_wdata_o,
  output logic          rvfi_mem_valid_o,
  output logic          err_o
);

  logic [1:0]             r_cnt;
  rvfi_mem_rec_t          r_part;
  logic                   r_err;
  rvfi_mem_rec_t          w_rec_cur;
  rvfi_mem_rec_t          w_head;
  rvfi_mem_rec_t          w_out;
  logic                   w_slot_free, w_accept, w_drop, w_we_mis, w_complete;
  logic                   w_bypass, w_underflow, w_push, w_pop, w_overflow;
  logic                   w_full, w_empty;
  logic [$clog2(DEPTH):0] w_occ;
  logic                   w_unused;

  assign w_unused = ^{lsu_data_trans_i.atop, lsu_data_trans_i.memtype,
                      lsu_data_trans_i.prot, lsu_data_trans_i.dbg, w_occ, w_full};

  // Current partial record with this cycle's transaction written into slot r_cnt
  always_comb begin
    w_rec_cur = r_part;
    w_rec_cur.addr[r_cnt[0]]  = lsu_data_trans_i.addr;
    w_rec_cur.be[r_cnt[0]]    = lsu_data_trans_i.be;
    w_rec_cur.wdata[r_cnt[0]] = lsu_data_trans_i.wdata;
    if (r_cnt == 2'd0) begin
      w_rec_cur.we = lsu_data_trans_i.we;
    end else begin
      w_rec_cur.we = r_part.we;
    end
  end

  assign w_slot_free = (r_cnt < 2'(MAX_TRANS));
  assign w_accept    = lsu_data_trans_valid_i && w_slot_free;
  assign w_drop      = lsu_data_trans_valid_i && !w_slot_free;
  assign w_we_mis    = w_accept && (r_cnt == 2'd1) && (lsu_data_trans_i.we != r_part.we);
  assign w_complete  = w_accept && lsu_trans_last_i;
  // A completing record can retire directly when nothing older is waiting
  assign w_bypass    = wb_lsu_retire_i && w_empty && w_complete;
  assign w_underflow = wb_lsu_retire_i && w_empty && !w_complete;
  assign w_push      = w_complete && !w_bypass && !flush_i;
  assign w_pop       = wb_lsu_retire_i && !w_empty;
  assign w_overflow  = w_push && w_full && !w_pop;

  cv32e40x_rvfi_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(rvfi_mem_rec_t))
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (flush_i),
    .i_wdata (w_rec_cur),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_cnt   (w_occ)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= 2'd0;
      r_part <= '0;
    end else if (flush_i || w_complete) begin
      r_cnt  <= 2'd0;
      r_part <= '0;
    end else if (w_accept) begin
      r_cnt  <= r_cnt + 2'd1;
      r_part <= w_rec_cur;
    end else begin
      r_cnt  <= r_cnt;
      r_part <= r_part;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_drop || w_we_mis || w_underflow || w_overflow) begin
      r_err <= 1'b1;
    end else begin
      r_err <= r_err;
    end
  end

  always_comb begin
    w_out = '0;
    if (w_pop) begin
      w_out = w_head;
    end else if (w_bypass) begin
      w_out = w_rec_cur;
    end else begin
      w_out = '0;
    end
  end

  assign rvfi_mem_addr_o  = w_out.addr;
  assign rvfi_mem_rmask_o = rec_mask(w_out, 1'b0);
  assign rvfi_mem_wmask_o = rec_mask(w_out, 1'b1);
  assign rvfi_mem_wdata_o = w_out.we ? w_out.wdata : 64'h0;
  assign rvfi_mem_valid_o = wb_lsu_retire_i;
  assign err_o            = r_err;

endmodule
